// File: rtl/path_tracer_pkg.sv
// -----------------------------------------------------------------------------
// path_tracer_pkg
// Shared definitions for the path tracer: default node-address width, default
// path-stack depth and the trace FSM state encoding.
// -----------------------------------------------------------------------------
package path_tracer_pkg;

   localparam int ADDR_W = 5;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      CAPTURE = 3'd2,
      EMIT    = 3'd3,
      FIN     = 3'd4,
      ERR     = 3'd5
   } state_e;

endpackage

// File: rtl/path_tracer_stack.sv
// -----------------------------------------------------------------------------
// path_stack
// LIFO of DEPTH node addresses used to reverse the predecessor walk
// (destination-first) into a source-first stream.
//   clk        : rising-edge clock
//   clear      : synchronous active-high reset of the entry count
//   push       : write push_data on top (ignored when full)
//   pop        : drop the top entry (ignored when empty)
//   flush      : discard all entries; wins over push/pop
//   push_data  : node written by push
//   top        : current top entry, 0 when empty
//   count      : number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module path_stack #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_d;
   logic [ADDR_W-1:0] top_idx;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && (count_q != FULL_COUNT);
   assign do_pop  = pop && (count_q != '0);

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (do_push) begin
         count_d = count_q + 1'b1;
      end else if (do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // NOTE: sequential state is assigned with non-blocking (<=) so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (clear) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // NOTE: the entry storage is deliberately not reset; only count_q defines
   // which entries are meaningful, so the array maps onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem_q[count_q[ADDR_W-1:0]] <= push_data;
      end
   end

   assign top_idx = count_q[ADDR_W-1:0] - ADDR_W'(1);
   assign top     = (count_q == '0) ? '0 : mem_q[top_idx];
   assign count   = count_q;

endmodule

// File: rtl/path_tracer.sv
// -----------------------------------------------------------------------------
// path_tracer
// Walks a Bellman-Ford predecessor table from dest back to source through the
// solver's stage-1 read port, stacking each node, then streams the path in
// source-first order over a valid/ready interface.
//   clk, clear               : clock and synchronous active-high reset
//   start                    : one-cycle trace request (IDLE only)
//   source_address           : source node, sampled with start
//   dest_address             : destination node, sampled with start
//   predecessor_rd_addr      : table read address to the solver (0 when idle)
//   stg1_mux_control         : high while the solver read port is borrowed
//   predecessor_out          : table data, valid one cycle after the address
//   path_valid/ready/node    : source-first path stream
//   path_last                : marks the destination beat
//   busy                     : high outside IDLE
//   done                     : one-cycle end-of-trace pulse
//   error                    : pulses with done when the trace failed
// -----------------------------------------------------------------------------
module path_tracer #(
   parameter int ADDR_W = path_tracer_pkg::ADDR_W,
   parameter int DEPTH  = path_tracer_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              start,
   input  logic [ADDR_W-1:0] source_address,
   input  logic [ADDR_W-1:0] dest_address,
   output logic [ADDR_W-1:0] predecessor_rd_addr,
   output logic              stg1_mux_control,
   input  logic [ADDR_W-1:0] predecessor_out,
   output logic              path_valid,
   input  logic              path_ready,
   output logic [ADDR_W-1:0] path_node,
   output logic              path_last,
   output logic              busy,
   output logic              done,
   output logic              error
);

   import path_tracer_pkg::*;

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_COUNT  = (ADDR_W + 1)'(1);

   state_e            state_q,   state_d;
   logic [ADDR_W-1:0] cur_q,     cur_d;
   logic [ADDR_W-1:0] src_q,     src_d;
   logic [ADDR_W-1:0] dst_q,     dst_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              mux_q,     mux_d;
   logic              valid_q,   valid_d;
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;
   logic              error_q,   error_d;

   logic              stk_push;
   logic              stk_pop;
   logic              stk_flush;
   logic [ADDR_W-1:0] stk_push_data;
   logic [ADDR_W-1:0] stk_top;
   logic [ADDR_W:0]   stk_count;

   // The latched destination is kept for observability of the active trace;
   // the walk itself only needs cur and the stack.
   logic              dst_unused;
   assign dst_unused = ^dst_q;

   path_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_stack (
      .clk       (clk),
      .clear     (clear),
      .push      (stk_push),
      .pop       (stk_pop),
      .flush     (stk_flush),
      .push_data (stk_push_data),
      .top       (stk_top),
      .count     (stk_count)
   );

   always_comb begin
      state_d       = state_q;
      cur_d         = cur_q;
      src_d         = src_q;
      dst_d         = dst_q;
      stk_push      = 1'b0;
      stk_pop       = 1'b0;
      stk_flush     = 1'b0;
      stk_push_data = predecessor_out;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               src_d         = source_address;
               dst_d         = dest_address;
               cur_d         = dest_address;
               stk_push      = 1'b1;
               stk_push_data = dest_address;
               state_d       = (dest_address == source_address) ? EMIT : READ;
            end
         end
         READ: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            // Reaching the source wins; a self-predecessor marks an
            // unreachable node; a full stack means the walk is looping.
            if (predecessor_out == src_q) begin
               stk_push = 1'b1;
               state_d  = EMIT;
            end else if (predecessor_out == cur_q) begin
               state_d = ERR;
            end else if (stk_count == FULL_COUNT) begin
               state_d = ERR;
            end else begin
               stk_push = 1'b1;
               cur_d    = predecessor_out;
               state_d  = READ;
            end
         end
         EMIT: begin
            if (valid_q && path_ready) begin
               stk_pop = 1'b1;
               if (stk_count == ONE_COUNT) begin
                  state_d = FIN;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         ERR: begin
            stk_flush = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      mux_d     = (state_d == READ) || (state_d == CAPTURE);
      rd_addr_d = mux_d ? cur_d : '0;
      valid_d   = (state_d == EMIT);
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == FIN) || (state_d == ERR);
      error_d   = (state_d == ERR);
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q   <= IDLE;
         cur_q     <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         rd_addr_q <= '0;
         mux_q     <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         rd_addr_q <= rd_addr_d;
         mux_q     <= mux_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign predecessor_rd_addr = rd_addr_q;
   assign stg1_mux_control    = mux_q;
   assign path_valid          = valid_q;
   assign path_node           = valid_q ? stk_top : '0;
   assign path_last           = valid_q && (stk_count == ONE_COUNT);
   assign busy                = busy_q;
   assign done                = done_q;
   assign error               = error_q;

endmodule

// File: doc/path_tracer.md
PATH_TRACER -- requirements
Module: path_tracer

Interface
REQ-001 Parameter ADDR_W, default 5, sets the node address width.
REQ-002 Parameter DEPTH, default 32 (2**ADDR_W), sets the path-stack entries and the maximum number of hops.
REQ-003 clk  input  1  sole clock; all logic is on the rising edge.
REQ-004 clear  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle request to trace a path; sampled only in IDLE.
REQ-006 source_address  input  ADDR_W  Bellman-Ford source node; sampled with start.
REQ-007 dest_address  input  ADDR_W  destination node; sampled with start.
REQ-008 predecessor_rd_addr  output  ADDR_W  predecessor-table read address, driven to the solver.
REQ-009 stg1_mux_control  output  1  high only while this block owns the solver's stage-1 read port.
REQ-010 predecessor_out  input  ADDR_W  predecessor data returned by the solver, valid 1 cycle after the address.
REQ-011 path_valid  output  1  path_node is valid.
REQ-012 path_ready  input  1  downstream accepts path_node.
REQ-013 path_node  output  ADDR_W  path node, emitted in source-first order.
REQ-014 path_last  output  1  qualifies the final (destination) node.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse marking the end of a trace.
REQ-017 error  output  1  one-cycle pulse, coincident with done, when the trace failed.

Function
REQ-018 FSM states SHALL be IDLE, READ, CAPTURE, EMIT, FIN, ERR.
REQ-019 IDLE + start: latch source_address/dest_address, push dest, cur<=dest; if dest==source go to EMIT, else go to READ.
REQ-020 READ (1 cycle): predecessor_rd_addr=cur, stg1_mux_control=1; next state is CAPTURE.
REQ-021 CAPTURE (1 cycle): stg1_mux_control stays 1; p=predecessor_out; decide in this priority order:
  - p==source: push p, go to EMIT.
  - p==cur (self-predecessor, unreachable): go to ERR.
  - stack count==DEPTH (loop/overflow): go to ERR.
  - otherwise: push p, cur<=p, go to READ.
REQ-022 Each hop SHALL cost exactly 2 cycles (READ+CAPTURE).
REQ-023 EMIT: path_valid=1, path_node=stack top, path_last=(count==1).
REQ-024 EMIT: pop on path_valid&&path_ready; path_node SHALL hold stable while path_ready=0.
REQ-025 Popping the last entry SHALL move the FSM to FIN.
REQ-026 FIN: done=1 for 1 cycle, then IDLE.
REQ-027 ERR: done=1 and error=1 for 1 cycle, stack flushed (count<=0), then IDLE; path_valid never asserts on an errored trace.
REQ-028 start outside IDLE SHALL be ignored, with no state change.
REQ-029 stg1_mux_control SHALL be 0 in IDLE, EMIT, FIN and ERR; predecessor_rd_addr SHALL be 0 whenever stg1_mux_control=0.
REQ-030 Stack push and pop SHALL never occur in the same cycle (push only in IDLE/CAPTURE, pop only in EMIT).
REQ-031 Stack count SHALL be ADDR_W+1 bits wide, range 0..DEPTH; push at count==DEPTH is unreachable by REQ-021.
REQ-032 Node comparisons SHALL be unsigned equality over ADDR_W bits, with no arithmetic wrap.

Reset
REQ-033 clear SHALL force state IDLE, stack count 0, and cur, latched source and latched dest to 0.
REQ-034 During and after clear: predecessor_rd_addr=0, stg1_mux_control=0, path_valid=0, path_node=0, path_last=0, busy=0, done=0, error=0.
REQ-035 clear asserted mid-trace or mid-emit SHALL abort without pulsing done or error; clear has priority over start.

Structure
REQ-036 Shared package path_tracer_pkg SHALL hold ADDR_W, DEPTH and the FSM state encoding.
REQ-037 The LIFO SHALL be a sub-module path_stack (DEPTH x ADDR_W, push/pop/flush, top, count); the FSM, the cur register and the latched source/dest registers stay in path_tracer.

Verification
REQ-038 Chain pred[7]=3, pred[3]=0, source=0, start dest=7, path_ready=1 -> reads at address 7 then 3; stream 0,3,7 with last on 7; done 1 cycle after the 7 handshake; busy for 8 cycles.
REQ-039 dest=source=4 -> no read (stg1_mux_control stays 0); single beat 4 with path_last=1; then done.
REQ-040 pred[9]=9, source=0, dest=9 -> one read, then done+error pulse; path_valid never high.
REQ-041 Cycle pred[5]=6, pred[6]=5, source=0, dest=5 -> error after DEPTH pushes (32 hops); no emission.
REQ-042 Chain of REQ-038 with path_ready toggling 0/1 each cycle -> same sequence 0,3,7, node held during stalls, no drop or duplicate; start pulsed during EMIT is ignored.
REQ-043 clear asserted in CAPTURE of the 2nd hop -> next cycle all outputs 0 and busy=0; a fresh start then traces correctly.
